mcu_block_reader: RTL
=====================

// Module: mcu_block_reader
// PURPOSE
//  Read side of the multi-line buffer. Drains BUF_AMOUNT per-line AXI4-Stream FIFOs (two banks of BLK_SIZE lines)
//  and emits one serial stream of BLK_SIZE x BLK_SIZE pixel blocks for the JPEG DCT stage.
//  Blocks are emitted left to right across a band. Pixels inside a block are row-major. Banks alternate per band (ping-pong).
// PARAMETERS
//  BLK_SIZE     8     block edge, in pixels and in lines
//  BUF_AMOUNT   16    line FIFOs on the input; must equal 2*BLK_SIZE
//  PX_WIDTH     8     pixel width; TDATA_WIDTH = PX_WIDTH rounded up to a multiple of 8
//  FRAME_RES_X  1280  line length in pixels; must be a multiple of BLK_SIZE
// PORTS
//  clk_i     in   1                              single clock
//  rst_i     in   1                              synchronous reset, active-high
//  lines_i   in   axi4_stream_if.slave  [BUF_AMOUNT-1:0]  line FIFO outputs; TDATA_WIDTH, TUSER=1
//  block_o   out  axi4_stream_if.master                  block stream; TDATA_WIDTH, TUSER=1
//  err_o     out  1                              sticky line-length/framing error
// BEHAVIOUR
//  Counters: px_cnt 0..BLK_SIZE-1, row_cnt 0..BLK_SIZE-1, blk_cnt 0..FRAME_RES_X/BLK_SIZE-1, bank 0..1.
//  Selected line: sel = bank*BLK_SIZE + row_cnt.
//  Input handshake:
//   - lines_i[sel].tready = out_free, where out_free = !block_o.tvalid || block_o.tready.
//   - tready of every other line is 0.
//   - A pop happens when lines_i[sel].tvalid && tready.
//  On each pop, advance:
//   - px_cnt.
//   - At px_cnt wrap: px_cnt->0, row_cnt++.
//   - At row_cnt wrap: row_cnt->0, blk_cnt++.
//   - At blk_cnt wrap: blk_cnt->0, bank toggles.
//  Output: one register stage, so latency is 1 clk and full throughput is 1 px/clk.
//   - tdata: copy of the popped tdata.
//   - tkeep/tstrb: all ones.
//   - tid/tdest: 0.
//   - tlast = 1 on the last pixel of each block (px_cnt, row_cnt both max).
//   - tuser = 1 on the first pixel of the frame's first block (input tuser seen at bank0, row0, blk0, px0).
//  Backpressure: block_o.tvalid and tdata hold stable while !tready. No input pop occurs while the output register is full and stalled.
//  Boundary checks (each sets err_o sticky until reset):
//   - Input tlast must be 1 exactly when blk_cnt, px_cnt are max. Mismatch -> err_o=1. Counters continue unchanged; no resync.
//   - Input tuser=1 at any position other than bank0/row0/blk0/px0 -> err_o=1. Output tuser stays 0 for that pixel.
//  Starvation: if the selected line is empty, stall. Never skip to another line; order is strictly fixed.
//  Simultaneous output accept and new pop in the same clk: the register reloads and tvalid stays 1 (no bubble).
//  Reset (synchronous, any cycle, including mid-block):
//   - All counters = 0, bank = 0.
//   - block_o.tvalid = 0, tlast = 0, tuser = 0, tdata = 0, err_o = 0.
//   - All lines_i tready = 0 during reset.
//   - Partially read FIFO contents are not flushed here; upstream FIFOs are reset by the same rst_i.
// STRUCTURE
//  Shared package jpeg_enc_pkg holds:
//   - BLK_SIZE constant.
//   - Function tdata_width(px_width), the byte-rounding rule shared with the line buffer.
//  Sub-module blk_scan_cnt holds the px/row/blk/bank counters.
//   - Input: advance. Outputs: sel, last_px_of_line, last_px_of_blk, frame_origin.
//   - Reused later by the decoder-side block writer.
//  Top: sel mux for tvalid/tdata/tlast/tuser, one-hot tready demux, output register, err logic.
// TESTING (BLK_SIZE=8, BUF_AMOUNT=16, FRAME_RES_X=16, PX_WIDTH=8)
//  1. Lines 0..15 preloaded with tdata = line*16 + x, tready=1.
//     -> First block is 0x00..07, 0x10..17, .., 0x70..77, tlast on 0x77.
//     -> Second block starts at 0x08.
//     -> Third block starts at 0x80 (bank 1). 256 beats, 4 tlast, tuser only on beat 0.
//  2. Same stimulus, block_o.tready toggled 1/0 each clk.
//     -> Identical data sequence; tdata held stable in stall cycles.
//     -> Selected-line tready low while stalled.
//  3. Line 3 delivers its pixels only after a 20-clk delay.
//     -> Output halts after row 2 of block 0 for 20 clks, then resumes at 0x30.
//     -> No line other than 3 is popped during the stall.
//  4. Line 1 asserts tlast at x=7 instead of x=15.
//     -> err_o=1 from the next clk onward; data order unchanged.
//  5. rst_i asserted 1 clk at beat 37, FIFOs refilled.
//     -> Next clk: tvalid=0, err_o=0. Restart emits 0x00 with tuser=1.
//  6. Two frames back to back, tuser on frame 2 line 0.
//     -> Output tuser exactly on beats 0 and 256; err_o stays 0.

Source files
------------

// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder constants and helpers.
// Block edge size and the TDATA byte-rounding rule used by the line buffer.
package jpeg_enc_pkg;

  localparam int BLK_SIZE = 8;

  function automatic int tdata_width(input int px_width);
    return ((px_width + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
// Carries tvalid/tready, tdata, tkeep, tstrb, tlast, tid, tdest, tuser.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 1
);

  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic                     tlast;
  logic [0:0]               tid;
  logic [0:0]               tdest;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb,
    output tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb,
    input  tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/blk_scan_cnt.sv
// Block scan position: px/row/blk counters plus ping-pong bank.
// In: clk_i, rst_i, advance. Out: sel, last_px_of_line, last_px_of_blk, frame_origin.
module blk_scan_cnt #(
  parameter int BLK_SIZE = 8,
  parameter int BLKS     = 160,
  localparam int PW = $clog2(BLK_SIZE),
  localparam int BW = (BLKS > 1) ? $clog2(BLKS) : 1,
  localparam int SW = $clog2(2 * BLK_SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          advance,
  output logic [SW-1:0] sel,
  output logic          last_px_of_line,
  output logic          last_px_of_blk,
  output logic          frame_origin
);

  logic [PW-1:0] px_cnt;
  logic [PW-1:0] row_cnt;
  logic [BW-1:0] blk_cnt;
  logic          bank;
  logic          px_max;
  logic          row_max;
  logic          blk_max;

  assign px_max  = (px_cnt == PW'(BLK_SIZE - 1));
  assign row_max = (row_cnt == PW'(BLK_SIZE - 1));
  assign blk_max = (blk_cnt == BW'(BLKS - 1));

  assign sel = SW'(row_cnt)
             + (bank ? SW'(BLK_SIZE) : SW'(0));

  assign last_px_of_line = blk_max && px_max;
  assign last_px_of_blk  = row_max && px_max;
  assign frame_origin    = !bank
                        && (row_cnt == '0)
                        && (blk_cnt == '0)
                        && (px_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_cnt  <= '0;
      row_cnt <= '0;
      blk_cnt <= '0;
      bank    <= 1'b0;
    end else if (advance) begin
      if (!px_max) begin
        px_cnt <= px_cnt + 1'b1;
      end else begin
        px_cnt <= '0;
        if (!row_max) begin
          row_cnt <= row_cnt + 1'b1;
        end else begin
          row_cnt <= '0;
          if (!blk_max) begin
            blk_cnt <= blk_cnt + 1'b1;
          end else begin
            blk_cnt <= '0;
            bank    <= ~bank;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mcu_block_reader.sv
// Drains per-line FIFOs into a serial stream of BLK_SIZE^2 pixel blocks.
// Ports: clk_i, rst_i, lines_i[] (slave), block_o (master), err_o (sticky).
module mcu_block_reader
  import jpeg_enc_pkg::*;
#(
  parameter int BLK_SIZE    = jpeg_enc_pkg::BLK_SIZE,
  parameter int BUF_AMOUNT  = 16,
  parameter int PX_WIDTH    = 8,
  parameter int FRAME_RES_X = 1280
) (
  input  logic         clk_i,
  input  logic         rst_i,
  axi4_stream_if.slave  lines_i [BUF_AMOUNT-1:0],
  axi4_stream_if.master block_o,
  output logic         err_o
);

  localparam int TDW  = tdata_width(PX_WIDTH);
  localparam int SW   = $clog2(2 * BLK_SIZE);
  localparam int BLKS = FRAME_RES_X / BLK_SIZE;

  logic [BUF_AMOUNT-1:0] l_vld;
  logic [BUF_AMOUNT-1:0] l_last;
  logic [BUF_AMOUNT-1:0] l_user;
  logic [TDW-1:0]        l_data [BUF_AMOUNT];

  logic [SW-1:0]  sel;
  logic           lpl;
  logic           lpb;
  logic           org;

  logic           s_vld;
  logic           s_last;
  logic           s_user;
  logic [TDW-1:0] s_data;

  logic           out_free;
  logic           rdy;
  logic           pop;

  logic           o_vld;
  logic           o_last;
  logic           o_user;
  logic [TDW-1:0] o_data;

  for (genvar g = 0; g < BUF_AMOUNT; g++) begin : g_line
    assign l_vld[g]  = lines_i[g].tvalid;
    assign l_last[g] = lines_i[g].tlast;
    assign l_user[g] = lines_i[g].tuser[0];
    assign l_data[g] = lines_i[g].tdata;
    assign lines_i[g].tready = rdy && (sel == SW'(g));
  end

  assign s_vld  = l_vld[sel];
  assign s_last = l_last[sel];
  assign s_user = l_user[sel];
  assign s_data = l_data[sel];

  // Reset forces every line's tready low.
  assign out_free = !o_vld || block_o.tready;
  assign rdy      = out_free && !rst_i;
  assign pop      = rdy && s_vld;

  blk_scan_cnt #(
    .BLK_SIZE (BLK_SIZE),
    .BLKS     (BLKS)
  ) u_cnt (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .advance         (pop),
    .sel             (sel),
    .last_px_of_line (lpl),
    .last_px_of_blk  (lpb),
    .frame_origin    (org)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      o_vld  <= 1'b0;
      o_last <= 1'b0;
      o_user <= 1'b0;
      o_data <= '0;
      err_o  <= 1'b0;
    end else begin
      if (pop) begin
        o_vld  <= 1'b1;
        o_data <= s_data;
        o_last <= lpb;
        o_user <= s_user && org;
      end else if (block_o.tready) begin
        o_vld <= 1'b0;
      end
      // Framing errors are flagged only; counters keep their pace.
      if (pop && ((s_last != lpl) || (s_user && !org))) begin
        err_o <= 1'b1;
      end
    end
  end

  assign block_o.tvalid = o_vld;
  assign block_o.tdata  = o_data;
  assign block_o.tlast  = o_last;
  assign block_o.tuser  = o_user;
  assign block_o.tkeep  = '1;
  assign block_o.tstrb  = '1;
  assign block_o.tid    = '0;
  assign block_o.tdest  = '0;

endmodule
